// File: rtl/orv64_bp_halt_ctrl.sv
// Breakpoint / debug halt controller for the ORV64 core.
// Collects breakpoint hits and debug halt requests, handshakes a pipeline
// halt with the core, handles resume and single-step, and keeps a halt
// counter plus a sticky halt-ack timeout flag.
module orv64_bp_halt_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bp_hit_if,
    input  logic             bp_hit_wb,
    input  logic             bp_hit_instret,
    input  logic             dbg_halt_req,
    input  logic             dbg_resume_req,
    input  logic             step_en,
    input  logic             core_halt_ack,
    input  logic             core_retire,
    output logic             core_halt_req,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic             resume_ack,
    output logic             halt_err,
    output logic [CNT_W-1:0] halt_cnt
);

    // Wait timer is at least 8 bits, wider if the timeout needs it.
    localparam int TMR_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] CAUSE_IF   = 3'd1;
    localparam logic [2:0] CAUSE_WB   = 3'd2;
    localparam logic [2:0] CAUSE_INST = 3'd3;
    localparam logic [2:0] CAUSE_DBG  = 3'd4;
    localparam logic [2:0] CAUSE_STEP = 3'd5;

    typedef enum logic [2:0] {
        S_RUN,
        S_HALT_REQ,
        S_HALTED,
        S_RESUME,
        S_STEP
    } state_t;

    state_t           state;
    logic             bp_mask;
    logic [TMR_W-1:0] timer;
    logic             bp_any;
    logic             trigger;
    logic [2:0]       trig_cause;

    assign bp_any  = bp_hit_if | bp_hit_wb | bp_hit_instret;
    assign trigger = dbg_halt_req | (~bp_mask & bp_any);

    // Halt cause priority: debug request beats any breakpoint source.
    always_comb begin
        trig_cause = 3'd0;
        if (dbg_halt_req)        trig_cause = CAUSE_DBG;
        else if (bp_hit_instret) trig_cause = CAUSE_INST;
        else if (bp_hit_wb)      trig_cause = CAUSE_WB;
        else if (bp_hit_if)      trig_cause = CAUSE_IF;
    end

    // Halt FSM with registered, state-aligned outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_RUN;
            bp_mask       <= 1'b0;
            timer         <= '0;
            core_halt_req <= 1'b0;
            halted        <= 1'b0;
            halt_cause    <= 3'd0;
            resume_ack    <= 1'b0;
            halt_err      <= 1'b0;
            halt_cnt      <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    // Mask uses its current value this cycle, so the retiring
                    // instruction's own breakpoint cannot re-trigger.
                    if (core_retire) bp_mask <= 1'b0;
                    if (trigger) begin
                        state         <= S_HALT_REQ;
                        halt_cause    <= trig_cause;
                        core_halt_req <= 1'b1;
                        timer         <= '0;
                    end
                end
                S_HALT_REQ: begin
                    if (core_halt_ack) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                        if (halt_cnt != '1) halt_cnt <= halt_cnt + CNT_ONE;
                    end else begin
                        if (timer != TMR_MAX) timer <= timer + TMR_ONE;
                        // Flag on the cycle the timer reaches TIMEOUT_CYC; keep waiting.
                        if (timer >= TMR_LAST) halt_err <= 1'b1;
                    end
                end
                S_HALTED: begin
                    // A trigger arriving with the resume is dropped.
                    if (dbg_resume_req) begin
                        state         <= S_RESUME;
                        halted        <= 1'b0;
                        core_halt_req <= 1'b0;
                        resume_ack    <= 1'b1;
                    end
                end
                S_RESUME: begin
                    resume_ack <= 1'b0;
                    bp_mask    <= 1'b1;
                    state      <= step_en ? S_STEP : S_RUN;
                end
                S_STEP: begin
                    // bp_mask is always set on entry here, so only debug
                    // requests and the stepped retire can halt.
                    if (core_retire) bp_mask <= 1'b0;
                    if (dbg_halt_req) begin
                        state         <= S_HALT_REQ;
                        halt_cause    <= CAUSE_DBG;
                        core_halt_req <= 1'b1;
                        timer         <= '0;
                    end else if (core_retire) begin
                        state         <= S_HALT_REQ;
                        halt_cause    <= CAUSE_STEP;
                        core_halt_req <= 1'b1;
                        timer         <= '0;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: doc/orv64_bp_halt_ctrl.md
ORV64_BP_HALT_CTRL -- requirements
Module: orv64_bp_halt_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max HALT_REQ cycles awaiting core_halt_ack before halt_err.
REQ-002 SHALL have parameter CNT_W, default 16, width of halt_cnt.
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port bp_hit_if  input  1  fetch-PC breakpoint match from breakpoint matcher.
REQ-006 SHALL have port bp_hit_wb  input  1  writeback-PC breakpoint match.
REQ-007 SHALL have port bp_hit_instret  input  1  instret breakpoint match.
REQ-008 SHALL have port dbg_halt_req  input  1  level halt request from debug module.
REQ-009 SHALL have port dbg_resume_req  input  1  single-cycle resume pulse from debug module.
REQ-010 SHALL have port step_en  input  1  single-step mode, sampled when leaving RESUME.
REQ-011 SHALL have port core_halt_ack  input  1  core pipeline drained and stopped.
REQ-012 SHALL have port core_retire  input  1  one instruction retired this cycle.
REQ-013 SHALL have port core_halt_req  output  1  stall/halt request to core.
REQ-014 SHALL have port halted  output  1  core confirmed halted.
REQ-015 SHALL have port halt_cause  output  3  0 none, 1 if, 2 wb, 3 instret, 4 dbg, 5 step.
REQ-016 SHALL have port resume_ack  output  1  single-cycle pulse on resume acceptance.
REQ-017 SHALL have port halt_err  output  1  sticky halt-ack timeout flag.
REQ-018 SHALL have port halt_cnt  output  CNT_W  saturating count of completed halts.

Function
REQ-019 SHALL implement FSM states RUN, HALT_REQ, HALTED, RESUME, STEP.
REQ-020 SHALL define trigger = dbg_halt_req | (~bp_mask & (bp_hit_if | bp_hit_wb | bp_hit_instret)).
REQ-021 RUN: trigger -> HALT_REQ next cycle; halt_cause latched same edge, priority dbg(4) > instret(3) > wb(2) > if(1).
REQ-022 core_halt_req SHALL be 1 in HALT_REQ and HALTED, 0 otherwise (registered, state-decoded).
REQ-023 HALT_REQ: core_halt_ack -> HALTED; halted=1 from that edge; halt_cnt +1, holds at 2^CNT_W-1.
REQ-024 HALT_REQ: 8-bit-or-wider wait timer counts each cycle without ack; reaching TIMEOUT_CYC sets halt_err, FSM stays HALT_REQ; timer clears on HALT_REQ entry.
REQ-025 HALTED: dbg_resume_req -> RESUME; halted clears on that edge.
REQ-026 RESUME: lasts exactly 1 cycle; resume_ack=1 only in this cycle; sets bp_mask; next state STEP if step_en else RUN.
REQ-027 bp_mask SHALL clear on first core_retire after RESUME, preventing immediate re-trigger at same PC.
REQ-028 STEP: core_retire -> HALT_REQ with halt_cause=5; dbg_halt_req without retire -> HALT_REQ cause 4; bp hits ignored while bp_mask=1.
REQ-029 halt_cause SHALL hold until next trigger latch; cleared to 0 only by reset.
REQ-030 SHALL ignore dbg_resume_req outside HALTED, core_halt_ack outside HALT_REQ, triggers in HALT_REQ/HALTED/RESUME.
REQ-031 Simultaneous dbg_resume_req and trigger in HALTED: resume taken; trigger discarded.
REQ-032 Simultaneous core_retire and trigger in STEP: cause 4 if dbg_halt_req, else 5.

Reset
REQ-033 rstn low SHALL immediately force RUN, bp_mask=0, timer=0, all outputs 0, halt_err=0, halt_cnt=0, regardless of state.
REQ-034 Reset deassertion SHALL require no handshake; first trigger honored on first posedge after release.

Verification
REQ-035 bp_hit_wb=1 one cycle in RUN, ack 3 cycles later -> core_halt_req=1 next cycle, halted=1 after ack edge, halt_cause=2, halt_cnt=1.
REQ-036 bp_hit_if=1, bp_hit_instret=1, dbg_halt_req=1 same cycle -> halt_cause=4.
REQ-037 Halted, resume pulse, bp_hit_if held 1, no retire -> resume_ack 1 cycle, no re-halt; after core_retire -> halt cause 1.
REQ-038 step_en=1, resume, core_retire after 5 cycles -> HALT_REQ, halt_cause=5, core_halt_req=1.
REQ-039 TIMEOUT_CYC=4, no ack -> halt_err=1 after 4 HALT_REQ cycles, core_halt_req stays 1; late ack -> halted=1, halt_err stays 1.
REQ-040 rstn low mid-HALT_REQ -> core_halt_req=0, halt_cause=0, halt_err=0 asynchronously; CNT_W=2, 5 halts -> halt_cnt=3.
